// File: rtl/tmp_sched_pkg.sv
// Shared types and constants for the temperature conversion scheduler.
// Holds the scheduler state encoding and the front-end reset length.
package tmp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FE_RESET,
        SETTLE,
        ACQUIRE,
        DONE,
        WAIT_PERIOD
    } tmp_sched_state_t;

    localparam int FE_RST_CYCLES = 2;

endpackage

// File: rtl/tmp_ones_counter.sv
// Sample counter and ones accumulator for one conversion window.
// Ports: clk, reset (sync, active high), clear, stb, inv, cmp;
//        full/half flag the strobe that completes the window/first half,
//        count is the ones total including the current strobe.
module tmp_ones_counter #(
    parameter int OSR_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              stb,
    input  logic              inv,
    input  logic              cmp,
    output logic              full,
    output logic              half,
    output logic [OSR_LOG2:0] count
);

    localparam int W = OSR_LOG2 + 1;
    localparam int N = 1 << OSR_LOG2;

    logic [W-1:0] samples;
    logic [W-1:0] ones;

    // count already includes the sample being strobed this cycle
    assign count = ones + W'(stb & (cmp ^ inv));
    assign full  = stb && (samples == W'(N - 1));
    assign half  = stb && (samples == W'(N / 2 - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            samples <= '0;
            ones    <= '0;
        end else if (stb) begin
            samples <= samples + W'(1);
            ones    <= count;
        end
    end

endmodule

// File: rtl/tmp_conv_sched.sv
// Conversion scheduler: front-end reset, settling, ones-count acquisition
// and valid/ready result delivery, one-shot or periodic.
// Ports: clk, reset (sync, active high), start, cont_en, sample_stb, cmp,
//        result_ready in; fe_rst, chop, busy, result, result_valid out.
// Optional feature: TMP_SCHED_CHOP_EN enables chopping in the second half.
module tmp_conv_sched
    import tmp_sched_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 32,
    parameter int OSR_LOG2       = 8,
    parameter int PERIOD         = 1024,
    parameter int RES_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont_en,
    input  logic             sample_stb,
    input  logic             cmp,
    input  logic             result_ready,
    output logic             fe_rst,
    output logic             chop,
    output logic             busy,
    output logic [RES_W-1:0] result,
    output logic             result_valid
);

    localparam int SW = $clog2(SETTLE_SAMPLES + 2);
    localparam int PW = $clog2(PERIOD + 1);

    tmp_sched_state_t state;
    tmp_sched_state_t next_state;

    logic [1:0]        rst_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [PW-1:0]     period_cnt;
    logic              acc_full;
    logic              acc_half;
    logic              acc_inv;
    logic [OSR_LOG2:0] acc_count;

    tmp_ones_counter #(
        .OSR_LOG2 (OSR_LOG2)
    ) u_ones (
        .clk   (clk),
        .reset (reset),
        .clear (state == FE_RESET),
        .stb   (sample_stb && (state == ACQUIRE)),
        .inv   (acc_inv),
        .cmp   (cmp),
        .full  (acc_full),
        .half  (acc_half),
        .count (acc_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start || cont_en) next_state = FE_RESET;
            end
            FE_RESET: begin
                if (rst_cnt == 2'(FE_RST_CYCLES - 1))
                    next_state = (SETTLE_SAMPLES == 0) ? ACQUIRE : SETTLE;
            end
            SETTLE: begin
                if (sample_stb && settle_cnt == SW'(SETTLE_SAMPLES - 1))
                    next_state = ACQUIRE;
            end
            ACQUIRE: begin
                if (acc_full) next_state = DONE;
            end
            DONE: begin
                if (result_ready)
                    next_state = cont_en ? WAIT_PERIOD : IDLE;
            end
            WAIT_PERIOD: begin
                if (!cont_en)
                    next_state = IDLE;
                else if (period_cnt == PW'(PERIOD - 1))
                    next_state = FE_RESET;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt    <= '0;
            settle_cnt <= '0;
            period_cnt <= '0;
        end else begin
            rst_cnt    <= (state == FE_RESET) ? rst_cnt + 2'd1 : 2'd0;
            period_cnt <= (state == WAIT_PERIOD) ? period_cnt + PW'(1) : '0;
            if (state == FE_RESET)
                settle_cnt <= '0;
            else if (state == SETTLE && sample_stb)
                settle_cnt <= settle_cnt + SW'(1);
        end
    end

    // Outputs are decoded from next_state so they line up with the state
    // register while still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            fe_rst       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            fe_rst       <= (next_state == FE_RESET);
            busy         <= !(next_state == IDLE || next_state == WAIT_PERIOD);
            result_valid <= (next_state == DONE);
            if (state == ACQUIRE && acc_full)
                result <= RES_W'(acc_count);
        end
    end

`ifdef TMP_SCHED_CHOP_EN
    // chop flips after the strobe that closes the first half, so every
    // second-half sample is accumulated inverted.
    always_ff @(posedge clk) begin
        if (reset || next_state != ACQUIRE)
            chop <= 1'b0;
        else if (acc_half)
            chop <= 1'b1;
    end
    assign acc_inv = chop;
`else
    logic unused_half;
    assign unused_half = acc_half;
    assign chop        = 1'b0;
    assign acc_inv     = 1'b0;
`endif

endmodule

// File: doc/tmp_conv_sched.md
# tmp_conv_sched

Conversion scheduler for the temperature/bandgap front-end controller. On a one-shot or periodic trigger it resets the front end and discards a fixed number of settling comparator samples. It then counts comparator ones over 2^OSR_LOG2 samples and presents the count as a conversion result on a valid/ready handshake. It sits between the register/host side and the front-end phase controller, which it drives only through `fe_rst` and `chop`.

## Interface
- `SETTLE_SAMPLES`, default 32: number of comparator samples discarded after a front-end reset.
- `OSR_LOG2`, default 8: log2 of the number of accumulated samples per conversion.
- `PERIOD`, default 1024: idle clock cycles between a result being accepted and the next conversion in continuous mode. Must be ≥ 1.
- `RES_W`, default 16: result width. Must be ≥ OSR_LOG2+1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request one conversion. Sampled only in IDLE.
- `cont_en` in 1: continuous mode. Level-sensitive.
- `sample_stb` in 1: one-cycle strobe from the front end; `cmp` is valid in this cycle.
- `cmp` in 1: comparator decision.
- `result_ready` in 1: consumer accepts the result.
- `fe_rst` out 1: front-end reset.
- `chop` out 1: front-end chopper polarity. Tied 0 unless TMP_SCHED_CHOP_EN is defined.
- `busy` out 1: a conversion is in progress or a result is pending.
- `result` out RES_W: ones count, zero-extended.
- `result_valid` out 1: result available.

## Operation
- States: IDLE, FE_RESET, SETTLE, ACQUIRE, DONE, WAIT_PERIOD.
- IDLE → FE_RESET when `start` is 1 or `cont_en` is 1.
- FE_RESET:
  - `fe_rst` is 1 for exactly 2 cycles.
  - Sample and ones counters are cleared.
  - Then → SETTLE.
- SETTLE:
  - Each `sample_stb` increments the settle counter.
  - After SETTLE_SAMPLES strobes → ACQUIRE.
  - `cmp` is ignored.
  - If SETTLE_SAMPLES=0, go directly to ACQUIRE.
- ACQUIRE:
  - Each `sample_stb` increments the sample counter and adds `cmp` to ones.
  - The ones counter is OSR_LOG2+1 bits. Maximum value is 2^OSR_LOG2, so it never wraps.
  - On the 2^OSR_LOG2-th strobe: `result` ← final ones (including this sample), then → DONE.
- DONE:
  - `result_valid` is 1 and `result` is held stable.
  - When `result_ready` is 1: → WAIT_PERIOD if `cont_en` is 1, else → IDLE.
- WAIT_PERIOD:
  - Counts PERIOD cycles, then → FE_RESET.
  - If `cont_en` is 0 in any cycle → IDLE immediately.
- `start` outside IDLE is ignored; there is no queuing.
- `sample_stb` in IDLE, FE_RESET, DONE or WAIT_PERIOD is ignored.
- `cont_en` deasserted during SETTLE or ACQUIRE: the current conversion completes normally.
- `reset` mid-operation aborts the conversion and discards partial counts.

## Timing
- Reset values:
  - state IDLE
  - `fe_rst` 0, `chop` 0, `busy` 0
  - `result` 0, `result_valid` 0
  - all counters 0
- All outputs are registered.
- `start` high in IDLE at cycle N → `fe_rst` and `busy` are 1 in cycles N+1 and N+2.
- `fe_rst` is 0 from cycle N+3 onward; SETTLE begins at N+3.
- Final ACQUIRE strobe at cycle M → `result_valid` is 1 from M+1.
- Handshake completes in a cycle with `result_valid` and `result_ready` both 1. `result_valid` is 0 the following cycle.
- `busy` is 0 in IDLE and WAIT_PERIOD and 1 in all other states.
- `result` keeps its last value after the handshake until the next conversion completes.

## Configuration
- Macro: `TMP_SCHED_CHOP_EN`.
- Defined:
  - `chop` is 0 during the first 2^(OSR_LOG2-1) ACQUIRE samples.
  - `chop` toggles to 1 registered on the strobe that completes the first half.
  - Second-half samples add `~cmp`.
  - `chop` returns to 0 in FE_RESET and stays 0 outside ACQUIRE.
  - Result range is unchanged.
- Undefined: `chop` is constant 0 and all samples add `cmp`.

## Structure
- Package `tmp_sched_pkg`:
  - state enum `tmp_sched_state_t`
  - `FE_RST_CYCLES` = 2
- Sub-module `tmp_ones_counter`:
  - sample counter and ones accumulator
  - clear, strobe and invert inputs
  - outputs: full flag, half flag and count
- The FSM, period timer and handshake stay in `tmp_conv_sched`.

## Test plan
Parameters: SETTLE_SAMPLES=2, OSR_LOG2=4, PERIOD=5.
- Single shot: `start` pulse, 18 strobes with `cmp`=1 → `fe_rst` high 2 cycles; result=16; `result_valid` 1 cycle after the 18th strobe; settling samples excluded.
- Pattern: `cmp` alternating 1,0 over the 16 acquire strobes → result=8. With TMP_SCHED_CHOP_EN, the same stimulus → result=8 and `chop` toggles after strobe 8.
- Backpressure: `result_ready`=0 for 10 cycles, with extra strobes and `start` pulses → `result` stable, no new conversion, `busy`=1.
- Continuous: `cont_en`=1 and `result_ready`=1 → the next `fe_rst` rises exactly 6 cycles after the handshake cycle (5 WAIT_PERIOD cycles, then the FE_RESET entry cycle). Dropping `cont_en` in WAIT_PERIOD → IDLE, no `fe_rst`.
- Reset mid-ACQUIRE after 7 strobes → all outputs at reset values next cycle; a new `start` yields a count of only the new samples.
- All-zero: 16 acquire strobes with `cmp`=0 → result=0. Without the macro, `chop` stays 0 throughout.
